ram_nport_init: RTL and testbench
=================================

# ram_nport_init

Parametrised memory with one write port and NUM_RD independent registered read ports, write-first forwarding on every read port, and a built-in clear engine that sweeps every entry to INIT_VALUE after reset or on request. It generalises the single-write/dual-read wrapper to an arbitrary read-port count. It is used for MMU tables, such as free lists and page-descriptor stores, that need several same-cycle lookups and a known power-on state. Storage is one dpram copy per read port, all fed by the common write port.

## Interface
- ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 64, bits per entry
- NUM_RD, 3, number of read ports (>=1)
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the clear engine
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear_req  input  1  pulse; restarts the clear sweep (honoured only when init_done=1)
- write_en  input  1  write strobe
- write_addr  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- read_en  input  NUM_RD  per-port read strobe
- read_addr  input  NUM_RD*ADDR_WIDTH  packed; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  output  NUM_RD*DATA_WIDTH  packed; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_valid  output  NUM_RD  per-port: read_data updated this cycle
- init_done  output  1  memory cleared and accepting traffic
- write_drop_err  output  1  sticky; a write was dropped during a sweep

## Operation
- FSM states:
  - CLEAR: a sweep counter writes INIT_VALUE to addresses 0..DEPTH-1, one per cycle, to all copies.
  - READY: normal traffic.
- Reset enters CLEAR with the counter at 0.
- CLEAR -> READY after address DEPTH-1 is written.
- READY -> CLEAR on clear_req=1. The counter restarts at 0.
- clear_req in CLEAR is ignored; it does not extend or restart the sweep.
- In CLEAR:
  - write_en=1 is dropped and sets write_drop_err. The flag is cleared only by rst_n.
  - read_en is ignored and read_valid stays 0.
- In READY:
  - write_en=1 writes write_data to write_addr in every copy.
  - Each port with read_en[i]=1 reads its own copy.
- Write-first forwarding: if write_en=1 and read_en[i]=1 with equal addresses in the same cycle, port i returns write_data, not the old contents.
- Ports are fully independent. Any number of ports may read the same or different addresses in the same cycle.
- read_data[i] holds its last value while read_en[i]=0.
- Address widths are exact. No out-of-range addresses exist and there is no wrap logic beyond the counter reaching DEPTH-1.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - read_data all 0
  - read_valid 0
  - init_done 0
  - write_drop_err 0
  - FSM in CLEAR, counter 0
- Sweep length:
  - After rst_n rises, the first clear write happens on the first edge.
  - init_done rises after exactly DEPTH edges and is registered; 64 edges for ADDR_WIDTH=6.
- clear_req sampled at edge t:
  - init_done=0 from edge t.
  - init_done=1 again after edge t+DEPTH.
- Read latency is 1 cycle. With read_en[i] and an address at edge t, read_data[i] and read_valid[i]=1 are visible after edge t. read_valid[i] is a one-cycle pulse per request.
- Write visibility:
  - A write at edge t is visible to a read sampled at edge t (forwarded) and all later reads.
  - A read sampled at edge t-1 returns the old value.
- The write is dropped and write_drop_err is set in the same cycle as:
  - the clear_req that triggers CLEAR;
  - any later cycle of the sweep, including the last.
- A write on the edge where init_done first reads 1 is accepted.
- rst_n asserted mid-sweep or mid-traffic immediately returns all outputs to reset values. Deassertion restarts the full sweep from address 0.

## Test plan
- Reset release, ADDR_WIDTH=6, INIT_VALUE=64'hDEAD: init_done rises exactly 64 cycles after rst_n rises. Reads of addresses 0, 31 and 63 on all ports then return 64'hDEAD with read_valid pulsing one cycle.
- Same-cycle forward: write 0x12→addr 5 while port 0 reads 5 and port 1 reads 6. Next cycle port 0=0x12 and port 1=INIT_VALUE. A read of 5 one cycle later on port 2 returns 0x12.
- All ports read different addresses written earlier (1→0xA, 2→0xB, 3→0xC) in one cycle: the ports return 0xA/0xB/0xC together. With read_en deasserted the outputs hold their values and read_valid=0.
- Writes during the sweep: write_en=1 at cycle 10 after reset → write_drop_err=1 and stays 1. After init_done, the targeted address still reads INIT_VALUE.
- clear_req after writing 0x77→addr 9: init_done drops next cycle and returns 64 cycles later. Addr 9 reads INIT_VALUE. A clear_req pulsed mid-sweep does not change the completion cycle.
- rst_n pulsed low at sweep count 30: all outputs return to reset values immediately, and init_done appears 64 cycles after rst_n releases.

Source files
------------

// File: rtl/ram_nport_init.sv
// One-write / NUM_RD-read memory with write-first forwarding and a clear engine
// that sweeps every entry to INIT_VALUE after reset or on clear_req.
module ram_nport_init #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_req,
    input  logic                         write_en,
    input  logic [ADDR_WIDTH-1:0]        write_addr,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [NUM_RD-1:0]            read_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
    output logic [NUM_RD-1:0]            read_valid,
    output logic                         init_done,
    output logic                         write_drop_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   count, count_next;
    logic                    wr_accept;
    logic                    wr_drop;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // clear_req is only honoured in READY; the write in that same cycle is dropped.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            CLEAR: begin
                count_next = count + 1'b1;
                if (&count) state_next = READY;
            end
            READY: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign init_done = (state == READY);
    assign wr_accept = write_en && (state == READY) && !clear_req;
    assign wr_drop   = write_en && ((state == CLEAR) || clear_req);

    assign mem_we   = (state == CLEAR) || wr_accept;
    assign mem_addr = (state == CLEAR) ? count : write_addr;
    assign mem_data = (state == CLEAR) ? INIT_VALUE : write_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       write_drop_err <= 1'b0;
        else if (wr_drop) write_drop_err <= 1'b1;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] ra;
        logic                  rd_go;
        logic [DATA_WIDTH-1:0] rd_data_p1;
        logic                  rd_vld_p1;

        assign ra    = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_go = read_en[i] && (state == READY);

        always_ff @(posedge clk) begin
            if (mem_we) mem[mem_addr] <= mem_data;
        end

        // ---- read stage p1: registered output, same-cycle write forwarded ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_p1 <= '0;
                rd_vld_p1  <= 1'b0;
            end else begin
                rd_vld_p1 <= rd_go;
                if (rd_go)
                    rd_data_p1 <= (wr_accept && (write_addr == ra)) ? write_data : mem[ra];
            end
        end

        assign read_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_p1;
        assign read_valid[i] = rd_vld_p1;
    end

endmodule

// File: tb/tb_ram_nport_init.sv
// Scoreboard bench for ram_nport_init: reads push expected data per port, a
// negedge monitor pops and compares whenever read_valid pulses.
module tb_ram_nport_init;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int NR = 3;
    localparam logic [DW-1:0] INIT = 64'hDEAD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_req;
    logic              write_en;
    logic [AW-1:0]     write_addr;
    logic [DW-1:0]     write_data;
    logic [NR-1:0]     read_en;
    logic [NR*AW-1:0]  read_addr;
    logic [NR*DW-1:0]  read_data;
    logic [NR-1:0]     read_valid;
    logic              init_done;
    logic              write_drop_err;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    ram_nport_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .INIT_VALUE(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .read_valid(read_valid), .init_done(init_done), .write_drop_err(write_drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        read_en[p] = 1'b1;
        read_addr[p*AW +: AW] = a;
        case (p)
            0: q0.push_back(exp);
            1: q1.push_back(exp);
            default: q2.push_back(exp);
        endcase
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic idle();
        read_en = '0;
        write_en = 1'b0;
        clear_req = 1'b0;
    endtask

    // Monitor: every read_valid pulse must match the oldest expectation for that port.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < NR; i++) begin
                if (read_valid[i]) begin
                    logic [DW-1:0] exp;
                    int empty;
                    empty = 0;
                    exp = '0;
                    case (i)
                        0: if (q0.size() == 0) empty = 1; else exp = q0.pop_front();
                        1: if (q1.size() == 0) empty = 1; else exp = q1.pop_front();
                        default: if (q2.size() == 0) empty = 1; else exp = q2.pop_front();
                    endcase
                    checks++;
                    if (empty != 0) begin
                        failures++;
                        $display("FAIL unexpected_valid port%0d: got valid with data %h required no valid", i, read_data[i*DW +: DW]);
                    end else if (read_data[i*DW +: DW] !== exp) begin
                        failures++;
                        $display("FAIL read_port%0d: got %h expected %h", i, read_data[i*DW +: DW], exp);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        write_addr = '0;
        write_data = '0;
        read_addr = '0;
        #22;
        check("rst_read_data", read_data[DW-1:0], '0);
        check("rst_read_valid", DW'(read_valid), '0);
        check("rst_init_done", DW'(init_done), '0);
        check("rst_err", DW'(write_drop_err), '0);
        mon_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep after reset, with a write attempted on edge 10.
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 9) wr(6'd20, 64'h55);
            if (k == 10) begin
                write_en = 1'b0;
                check("err_set_in_sweep", DW'(write_drop_err), 64'd1);
            end
            if (k == 63) check("init_done_edge63", DW'(init_done), 64'd0);
            if (k == 64) check("init_done_edge64", DW'(init_done), 64'd1);
        end
        check("err_sticky", DW'(write_drop_err), 64'd1);

        // Addresses 0, 31, 63 on every port, rotated.
        rd(0, 6'd0, INIT);  rd(1, 6'd31, INIT); rd(2, 6'd63, INIT); step();
        rd(0, 6'd31, INIT); rd(1, 6'd63, INIT); rd(2, 6'd0, INIT);  step();
        rd(0, 6'd63, INIT); rd(1, 6'd0, INIT);  rd(2, 6'd31, INIT); step();
        rd(0, 6'd20, INIT); read_en[1] = 1'b0; read_en[2] = 1'b0; step();
        idle(); step();
        check("valid_pulse_one_cycle", DW'(read_valid), '0);

        // Same-cycle forward versus neighbouring address.
        wr(6'd5, 64'h12); rd(0, 6'd5, 64'h12); rd(1, 6'd6, INIT); step();
        idle(); rd(2, 6'd5, 64'h12); step();
        idle();

        // Three ports, three distinct addresses, then hold.
        wr(6'd1, 64'hA); step();
        wr(6'd2, 64'hB); step();
        wr(6'd3, 64'hC); step();
        idle(); rd(0, 6'd1, 64'hA); rd(1, 6'd2, 64'hB); rd(2, 6'd3, 64'hC); step();
        idle(); step(); step();
        check("hold_valid", DW'(read_valid), '0);
        check("hold_port0", read_data[0*DW +: DW], 64'hA);
        check("hold_port1", read_data[1*DW +: DW], 64'hB);
        check("hold_port2", read_data[2*DW +: DW], 64'hC);

        // clear_req after a write; mid-sweep clear_req must not move completion.
        wr(6'd9, 64'h77); step();
        idle(); rd(0, 6'd9, 64'h77); step();
        idle(); clear_req = 1'b1; step();
        check("clear_drops_init_done", DW'(init_done), '0);
        clear_req = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 20) clear_req = 1'b1;
            if (k == 10) rd(1, 6'd9, 64'h0);
            step();
            clear_req = 1'b0;
            read_en = '0;
            if (k == 11) check("no_valid_in_sweep", DW'(read_valid), '0);
            if (k == 63) check("clear_done_edge63", DW'(init_done), '0);
            if (k == 64) check("clear_done_edge64", DW'(init_done), 64'd1);
        end
        // The read queued at k==10 must never appear; drop it.
        q1.delete();
        wr(6'd7, 64'h99); rd(1, 6'd9, INIT); rd(2, 6'd5, INIT); step();
        idle(); rd(0, 6'd7, 64'h99); step();
        idle(); step();

        // Reset asserted 30 cycles into a clear sweep.
        clear_req = 1'b1; step();
        clear_req = 1'b0;
        for (int k = 1; k <= 30; k++) step();
        rst_n = 1'b0;
        #1;
        check("midreset_data0", read_data[0*DW +: DW], '0);
        check("midreset_data1", read_data[1*DW +: DW], '0);
        check("midreset_err", DW'(write_drop_err), '0);
        check("midreset_init_done", DW'(init_done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 63) check("rst2_edge63", DW'(init_done), '0);
            if (k == 64) check("rst2_edge64", DW'(init_done), 64'd1);
        end
        rd(0, 6'd9, INIT); rd(1, 6'd7, INIT); rd(2, 6'd63, INIT); step();
        idle(); step(); step();
        check("err_clear_after_rst", DW'(write_drop_err), '0);
        check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
